cmult_seq_ctrl: RTL and testbench

CMULT_SEQ_CTRL -- requirements
Module: cmult_seq_ctrl

---
 rtl/cmult_seq_ctrl_if.sv | 29 ++
 rtl/cmult_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cmult_seq_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmult_seq_ctrl_if.sv
// Handshake and operand/result bundle for the sequential complex multiplier.
// master = operand producer / result consumer, slave = the multiplier itself.
interface cmult_seq_ctrl_if #(
  parameter int DATA_W = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] a_re;
  logic signed [DATA_W-1:0] a_im;
  logic signed [DATA_W-1:0] b_re;
  logic signed [DATA_W-1:0] b_im;
  logic signed [DATA_W-1:0] out_re;
  logic signed [DATA_W-1:0] out_im;
  logic                     ovf_re;
  logic                     ovf_im;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  modport master (
    output in_valid, a_re, a_im, b_re, b_im, out_ready,
    input  in_ready, out_re, out_im, ovf_re, ovf_im, out_valid, busy
  );

  modport slave (
    input  in_valid, a_re, a_im, b_re, b_im, out_ready,
    output in_ready, out_re, out_im, ovf_re, ovf_im, out_valid, busy
  );
endinterface

// File: rtl/cmult_seq_ctrl.sv
// Sequential fixed-point complex multiplier: one shared real multiplier is
// stepped through the four partial products, then re = P0-P1, im = P2+P3.
module cmult_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int FRAC_W = 5,
  parameter int INT_W  = 2
) (
  input logic             clk,
  input logic             rst,
  cmult_seq_ctrl_if.slave bus
);

  localparam int W2 = 2 * DATA_W;
  // Lowest full-product bit kept by the multiplier (defaults: 5, keeping [11:5]).
  localparam int LO = 2 * FRAC_W + INT_W + 1 - DATA_W;

  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, DONE} state_e;

  // Fractional product: sign is the XOR of operand signs, remaining bits are the
  // scaled magnitude field of the full product; a zero operand forces zero.
  function automatic logic signed [DATA_W-1:0] pmul(
    input logic signed [DATA_W-1:0] x,
    input logic signed [DATA_W-1:0] y
  );
    logic signed [W2-1:0]     f;
    logic signed [DATA_W-1:0] r;
    f = W2'(x) * W2'(y);
    r = DATA_W'(f >>> LO);
    r[DATA_W-1] = x[DATA_W-1] ^ y[DATA_W-1];
    if (x == '0 || y == '0) r = '0;
    return r;
  endfunction

  // Wrapping add/sub; MSB of the return value is the signed-overflow flag.
  function automatic logic [DATA_W:0] addsub(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b,
    input logic                     sub
  );
    logic signed [DATA_W:0] s;
    s = sub ? ((DATA_W+1)'(a) - (DATA_W+1)'(b))
            : ((DATA_W+1)'(a) + (DATA_W+1)'(b));
    return {s[DATA_W] ^ s[DATA_W-1], s[DATA_W-1:0]};
  endfunction

  state_e                   state_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic                     busy_q;
  logic signed [DATA_W-1:0] opa_re_q;
  logic signed [DATA_W-1:0] opa_im_q;
  logic signed [DATA_W-1:0] opb_re_q;
  logic signed [DATA_W-1:0] opb_im_q;
  logic signed [DATA_W-1:0] mul_q;
  logic signed [DATA_W-1:0] p0_q;
  logic signed [DATA_W-1:0] p1_q;
  logic signed [DATA_W-1:0] out_re_q;
  logic signed [DATA_W-1:0] out_im_q;
  logic                     ovf_re_q;
  logic                     ovf_im_q;

  logic signed [DATA_W-1:0] mul_x_d;
  logic signed [DATA_W-1:0] mul_y_d;
  logic signed [DATA_W-1:0] prod_d;
  logic        [DATA_W:0]   sub_d;
  logic        [DATA_W:0]   add_d;

  // Operand steering for the single multiplier, one partial product per state.
  always_comb begin
    mul_x_d = opa_re_q;
    mul_y_d = opb_re_q;
    case (state_q)
      M1: begin
        mul_x_d = opa_im_q;
        mul_y_d = opb_im_q;
      end
      M2: begin
        mul_x_d = opa_re_q;
        mul_y_d = opb_im_q;
      end
      M3: begin
        mul_x_d = opa_im_q;
        mul_y_d = opb_re_q;
      end
      default: ;
    endcase
  end

  // In M3, mul_q holds P2 while the multiplier is producing P3.
  assign prod_d = pmul(mul_x_d, mul_y_d);
  assign sub_d  = addsub(p0_q, p1_q, 1'b1);
  assign add_d  = addsub(mul_q, prod_d, 1'b0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      opa_re_q    <= '0;
      opa_im_q    <= '0;
      opb_re_q    <= '0;
      opb_im_q    <= '0;
      mul_q       <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      ovf_re_q    <= 1'b0;
      ovf_im_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            opa_re_q   <= bus.a_re;
            opa_im_q   <= bus.a_im;
            opb_re_q   <= bus.b_re;
            opb_im_q   <= bus.b_im;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= M0;
          end
        end
        M0: begin
          mul_q   <= prod_d;
          state_q <= M1;
        end
        M1: begin
          mul_q   <= prod_d;
          p0_q    <= mul_q;
          state_q <= M2;
        end
        M2: begin
          mul_q   <= prod_d;
          p1_q    <= mul_q;
          state_q <= M3;
        end
        M3: begin
          mul_q       <= prod_d;
          out_re_q    <= sub_d[DATA_W-1:0];
          ovf_re_q    <= sub_d[DATA_W];
          out_im_q    <= add_d[DATA_W-1:0];
          ovf_im_q    <= add_d[DATA_W];
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_re    = out_re_q;
  assign bus.out_im    = out_im_q;
  assign bus.ovf_re    = ovf_re_q;
  assign bus.ovf_im    = ovf_im_q;

endmodule

// File: tb/tb_cmult_seq_ctrl.sv
// Bench for cmult_seq_ctrl: fixed vectors, hand-built corner sequences and a
// randomized stream checked against an arithmetic reference model.
module tb_cmult_seq_ctrl;

  localparam int DW   = 8;
  localparam int FW   = 5;
  localparam int IW   = 2;
  localparam int SH   = 2 * FW + IW + 1 - DW;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  typedef struct {
    logic [DW-1:0] ar, ai, br, bi;
    logic [DW-1:0] er, ei;
    logic          eor, eoi;
  } vec_t;

  typedef struct {
    logic [DW-1:0] re, im;
    logic          ore, oim;
    int            acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;
  vec_t tbl[8];
  exp_t q[$];

  cmult_seq_ctrl_if #(.DATA_W(DW)) bus ();

  cmult_seq_ctrl #(.DATA_W(DW), .FRAC_W(FW), .INT_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] z(input logic [DW-1:0] v);
    return 32'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int s(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  // Real product: sign from the operand signs, magnitude field = low DW-1 bits
  // of floor(x*y / 2^SH); zero whenever an operand is zero.
  function automatic logic [DW-1:0] pref(input logic [DW-1:0] x, input logic [DW-1:0] y);
    int f, mag, sgn;
    if (s(x) == 0 || s(y) == 0) return '0;
    f   = s(x) * s(y);
    mag = (f >>> SH) & MAXV;
    sgn = ((s(x) < 0) != (s(y) < 0)) ? 1 : 0;
    return DW'(sgn * (MAXV + 1) + mag);
  endfunction

  function automatic exp_t model(input logic [DW-1:0] ar, ai, br, bi, input int acc);
    exp_t e;
    int   re, im;
    re    = s(pref(ar, br)) - s(pref(ai, bi));
    im    = s(pref(ar, bi)) + s(pref(ai, br));
    e.re  = DW'(re);
    e.im  = DW'(im);
    e.ore = (re > MAXV) || (re < MINV);
    e.oim = (im > MAXV) || (im < MINV);
    e.acc = acc;
    return e;
  endfunction

  task automatic rand_ops();
    bus.a_re = DW'($urandom);
    bus.a_im = DW'($urandom);
    bus.b_re = DW'($urandom);
    bus.b_im = DW'($urandom);
  endtask

  // Starts in IDLE; returns in the first cycle with out_valid high (or timeout).
  task automatic run_op(input logic [DW-1:0] ar, ai, br, bi, input logic ordy,
                        output int lat);
    bus.a_re      = ar;
    bus.a_im      = ai;
    bus.b_re      = br;
    bus.b_im      = bi;
    bus.in_valid  = 1'b1;
    bus.out_ready = ordy;
    tick();
    bus.in_valid = 1'b0;
    rand_ops();
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // mode 0: random valid/ready, 1: both held high, 2: drain (no new input)
  task automatic stream(input int ncyc, input int mode);
    int            last_acc;
    logic          prev_stall;
    logic [DW-1:0] prev_re, prev_im;
    logic          prev_ore, prev_oim, prev_vld;
    logic          iv, ordy;
    exp_t          e;
    last_acc   = -1;
    prev_stall = 1'b0;
    prev_vld   = bus.out_valid;
    prev_re    = '0;
    prev_im    = '0;
    prev_ore   = 1'b0;
    prev_oim   = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      iv   = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
      ordy = (mode != 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      rand_ops();
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 1);
        chk("hold_re", z(bus.out_re), z(prev_re));
        chk("hold_im", z(bus.out_im), z(prev_im));
        chk("hold_ovf", {30'd0, bus.ovf_re, bus.ovf_im}, {30'd0, prev_ore, prev_oim});
      end
      if (bus.out_valid && !prev_vld) begin
        if (q.size() == 0) chk("result_unexpected", 1, 0);
        else chk("latency", 32'(cyc - q[0].acc), 5);
      end
      if (bus.in_ready && iv) begin
        q.push_back(model(bus.a_re, bus.a_im, bus.b_re, bus.b_im, cyc));
        if (mode == 1 && last_acc >= 0) chk("accept_gap", 32'(cyc - last_acc), 6);
        last_acc = cyc;
      end
      if (bus.out_valid && ordy) begin
        if (q.size() == 0) begin
          chk("result_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk("stream_re", z(bus.out_re), z(e.re));
          chk("stream_im", z(bus.out_im), z(e.im));
          chk("stream_ovf", {30'd0, bus.ovf_re, bus.ovf_im}, {30'd0, e.ore, e.oim});
        end
      end
      prev_stall = bus.out_valid && !ordy;
      prev_vld   = bus.out_valid;
      prev_re    = bus.out_re;
      prev_im    = bus.out_im;
      prev_ore   = bus.ovf_re;
      prev_oim   = bus.ovf_im;
      tick();
    end
  endtask

  initial begin
    int            lat;
    int            seen;
    logic [DW-1:0] r_re, r_im;
    logic          r_ore, r_oim;

    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_re = '0; bus.a_im = '0; bus.b_re = '0; bus.b_im = '0;

    tbl[0] = '{8'h20, 8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{8'h10, 8'h10, 8'h10, 8'hF0, 8'h10, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{8'h60, 8'h60, 8'h20, 8'hE0, 8'hC0, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h40, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 8'h55, 8'hAA, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{8'hE0, 8'h00, 8'h20, 8'h00, 8'hE0, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{8'h60, 8'h60, 8'h20, 8'h20, 8'h00, 8'hC0, 1'b0, 1'b1};
    tbl[7] = '{8'h7F, 8'h00, 8'h7F, 8'h00, 8'h78, 8'h00, 1'b0, 1'b0};

    tick();
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_out_re", z(bus.out_re), 0);
    chk("rst_out_im", z(bus.out_im), 0);
    chk("rst_ovf", {30'd0, bus.ovf_re, bus.ovf_im}, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].ar, tbl[i].ai, tbl[i].br, tbl[i].bi, 1'b1, lat);
      chk("vec_latency", 32'(lat), 5);
      chk("vec_busy", 32'(bus.busy), 1);
      chk("vec_re", z(bus.out_re), z(tbl[i].er));
      chk("vec_im", z(bus.out_im), z(tbl[i].ei));
      chk("vec_ovf_re", 32'(bus.ovf_re), 32'(tbl[i].eor));
      chk("vec_ovf_im", 32'(bus.ovf_im), 32'(tbl[i].eoi));
      tick();
      chk("vec_back_idle", 32'(bus.in_ready), 1);
      chk("vec_valid_drop", 32'(bus.out_valid), 0);
      chk("vec_re_kept", z(bus.out_re), z(tbl[i].er));
      chk("vec_im_kept", z(bus.out_im), z(tbl[i].ei));
    end

    // Back-pressure in DONE while new operands are offered.
    run_op(8'h20, 8'h20, 8'h20, 8'h20, 1'b0, lat);
    chk("stall_latency", 32'(lat), 5);
    r_re = bus.out_re; r_im = bus.out_im; r_ore = bus.ovf_re; r_oim = bus.ovf_im;
    chk("stall_re", z(r_re), 32'h00);
    chk("stall_im", z(r_im), 32'h40);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      tick();
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_in_ready", 32'(bus.in_ready), 0);
      chk("stall_re_hold", z(bus.out_re), z(r_re));
      chk("stall_im_hold", z(bus.out_im), z(r_im));
      chk("stall_ovf_hold", {30'd0, bus.ovf_re, bus.ovf_im}, {30'd0, r_ore, r_oim});
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("stall_release_idle", 32'(bus.in_ready), 1);
    chk("stall_release_busy", 32'(bus.busy), 0);
    chk("stall_release_valid", 32'(bus.out_valid), 0);

    // Reset while in M2.
    bus.a_re = 8'h60; bus.a_im = 8'h60; bus.b_re = 8'h20; bus.b_im = 8'hE0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("m2_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("m2rst_in_ready", 32'(bus.in_ready), 1);
    chk("m2rst_busy", 32'(bus.busy), 0);
    chk("m2rst_out_valid", 32'(bus.out_valid), 0);
    chk("m2rst_out_re", z(bus.out_re), 0);
    chk("m2rst_out_im", z(bus.out_im), 0);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("m2rst_no_result", 32'(seen), 0);

    // Reset in DONE with out_ready=1 must win over the handshake.
    run_op(8'h10, 8'h10, 8'h10, 8'hF0, 1'b1, lat);
    chk("done_pre_re", z(bus.out_re), 32'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("donerst_out_valid", 32'(bus.out_valid), 0);
    chk("donerst_out_re", z(bus.out_re), 0);
    chk("donerst_in_ready", 32'(bus.in_ready), 1);
    tick();

    stream(300, 1);
    stream(20, 2);
    stream(800, 0);
    stream(20, 2);
    chk("drain_empty", 32'(q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
